// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared vector-unit op encodings and scratchpad tile sequencer types
package vector_pkg;

  localparam logic [6:0] VOP_LOAD  = 7'b0000111;
  localparam logic [6:0] VOP_STORE = 7'b0100111;

  localparam logic SP_ROW_MAJOR = 1'b0;
  localparam logic SP_COL_MAJOR = 1'b1;

  localparam int SP_ADDR_W = 16;

  typedef enum logic [2:0] {
    SP_IDLE,
    SP_STORE,
    SP_LOAD,
    SP_DRAIN,
    SP_DONE
  } sp_state_t;

  typedef struct packed {
    logic [6:0]           op;
    logic [SP_ADDR_W-1:0] addr;
    logic                 row_col;
    logic [5:0]           rows;
    logic [5:0]           cols;
    logic                 id;
  } sp_req_t;

endpackage

// File: rtl/sp_tile_addr_gen.sv
// rtl/sp_tile_addr_gen.sv - outer/inner tile walk counters and element word address
// With SP_BOUNDS_CHECK_EN, oob_o flags walk addresses at or beyond SP_DEPTH.
module sp_tile_addr_gen
  import vector_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 32,
  parameter int SP_DEPTH   = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              go_i,
  input  logic              row_col_i,
  input  logic [5:0]        rows_i,
  input  logic [5:0]        cols_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              advance_o,
  output logic              oob_o
);

  logic [5:0]  outer_q, outer_d;
  logic [5:0]  inner_q, inner_d;
  logic [11:0] elem_q, elem_d;
  logic [5:0]  inner_max;
  logic [5:0]  row, col;
  logic [11:0] total;

  assign inner_max = (row_col_i == SP_COL_MAJOR) ? rows_i : cols_i;
  assign row       = (row_col_i == SP_COL_MAJOR) ? inner_q : outer_q;
  assign col       = (row_col_i == SP_COL_MAJOR) ? outer_q : inner_q;
  assign total     = 12'(rows_i) * 12'(cols_i);
  assign last_o    = (elem_q == total - 12'd1);
  assign advance_o = go_i;

  always_comb begin
    outer_d = outer_q;
    inner_d = inner_q;
    elem_d  = elem_q;
    if (start_i) begin
      outer_d = '0;
      inner_d = '0;
      elem_d  = '0;
    end else if (go_i) begin
      elem_d = elem_q + 12'd1;
      if (inner_q == inner_max - 6'd1) begin
        inner_d = '0;
        outer_d = outer_q + 6'd1;
      end else begin
        inner_d = inner_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outer_q <= '0;
      inner_q <= '0;
      elem_q  <= '0;
    end else begin
      outer_q <= outer_d;
      inner_q <= inner_d;
      elem_q  <= elem_d;
    end
  end

`ifdef SP_BOUNDS_CHECK_EN
  localparam int AW = ADDR_W + 8;
  logic [AW-1:0] full_addr;

  // Range test uses the untruncated sum so wrapped addresses still count as out of range.
  assign full_addr = AW'(base_i) + AW'(row) * AW'(ROW_STRIDE) + AW'(col);
  assign addr_o    = full_addr[ADDR_W-1:0];
  assign oob_o     = (full_addr >= AW'(SP_DEPTH));
`else
  logic unused_depth;

  assign addr_o       = base_i + ADDR_W'(row) * ADDR_W'(ROW_STRIDE) + ADDR_W'(col);
  assign oob_o        = 1'b0;
  assign unused_depth = ^SP_DEPTH;
`endif

endmodule

// File: rtl/sp_tile_seq.sv
// rtl/sp_tile_seq.sv - scratchpad tile sequencer: walks one load/store tile over a 1-cycle SRAM
// Optional SP_BOUNDS_CHECK_EN suppresses accesses at or beyond SP_DEPTH and reports resp_err.
module sp_tile_seq
  import vector_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int ROW_STRIDE = 32,
  parameter int SP_DEPTH   = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_row_col,
  input  logic [5:0]        req_num_rows,
  input  logic [5:0]        req_num_cols,
  input  logic              req_id,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              dhit,
  output logic              resp_id,
  output logic              resp_err
);

  sp_state_t         state_q, state_d;
  sp_req_t           req_q, req_d;
  logic              rd_valid_q, rd_valid_d;
  logic              start, go, advance, last, oob;
  logic              is_load, is_store, zero_dim;
  logic [ADDR_W-1:0] walk_addr;

  assign is_load  = (req_op == VOP_LOAD);
  assign is_store = (req_op == VOP_STORE);
  assign zero_dim = (req_num_rows == 6'd0) || (req_num_cols == 6'd0);
  assign start    = (state_q == SP_IDLE) && req_valid;

  sp_tile_addr_gen #(
    .ADDR_W    (ADDR_W),
    .ROW_STRIDE(ROW_STRIDE),
    .SP_DEPTH  (SP_DEPTH)
  ) u_addr_gen (
    .clk_i    (CLK),
    .rst_i    (RST),
    .start_i  (start),
    .go_i     (go),
    .row_col_i(req_q.row_col),
    .rows_i   (req_q.rows),
    .cols_i   (req_q.cols),
    .base_i   (ADDR_W'(req_q.addr)),
    .addr_o   (walk_addr),
    .last_o   (last),
    .advance_o(advance),
    .oob_o    (oob)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    go      = 1'b0;
    case (state_q)
      SP_IDLE: begin
        if (req_valid) begin
          req_d.op      = req_op;
          req_d.addr    = SP_ADDR_W'(req_addr);
          req_d.row_col = req_row_col;
          req_d.rows    = req_num_rows;
          req_d.cols    = req_num_cols;
          req_d.id      = req_id;
          // Unsupported ops are consumed here and never answered.
          if (is_load || is_store) begin
            if (zero_dim)     state_d = SP_DONE;
            else if (is_load) state_d = SP_LOAD;
            else              state_d = SP_STORE;
          end
        end
      end
      SP_STORE: begin
        go = wr_valid;
        if (advance && last) state_d = SP_DONE;
      end
      SP_LOAD: begin
        go = 1'b1;
        if (last) state_d = SP_DRAIN;
      end
      SP_DRAIN: state_d = SP_DONE;
      SP_DONE:  state_d = SP_IDLE;
      default:  state_d = SP_IDLE;
    endcase
  end

  assign rd_valid_d = advance && (state_q == SP_LOAD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= SP_IDLE;
      req_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign req_ready  = (state_q == SP_IDLE);
  assign wr_ready   = (state_q == SP_STORE);
  assign sram_en    = advance & ~oob;
  assign sram_we    = sram_en & (req_q.op == VOP_STORE);
  assign sram_addr  = sram_en ? walk_addr : '0;
  assign sram_wdata = sram_we ? wr_data : '0;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = (state_q == SP_DRAIN);
  assign dhit       = (state_q == SP_DONE);
  assign resp_id    = dhit & req_q.id;

`ifdef SP_BOUNDS_CHECK_EN
  logic err_q;
  logic rd_supp_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q     <= 1'b0;
      rd_supp_q <= 1'b0;
    end else begin
      rd_supp_q <= rd_valid_d & oob;
      if (start)              err_q <= 1'b0;
      else if (advance & oob) err_q <= 1'b1;
    end
  end

  assign rd_data  = (rd_valid_q & ~rd_supp_q) ? sram_rdata : '0;
  assign resp_err = dhit & err_q;
`else
  assign rd_data  = rd_valid_q ? sram_rdata : '0;
  assign resp_err = 1'b0;
`endif

endmodule

// File: doc/sp_tile_seq.md
Name: sp_tile_seq

Overview:
Scratchpad tile sequencer, directly downstream of the vector load/store unit. Accepts one tile request: op, base address, row/column order, tile dimensions and id. Walks every element of the tile against a single-port scratchpad SRAM with 1-cycle read latency. Streams store data in and load data out, then pulses dhit back to the load/store unit on completion. The lane-A and lane-B request paths each instantiate one copy.

Parameters:
ADDR_W, 16, scratchpad word-address width
DATA_W, 16, element width
ROW_STRIDE, 32, words between consecutive rows of a tile
SP_DEPTH, 4096, scratchpad words; used only by the optional feature

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
req_valid  in  1  tile request valid
req_ready  out  1  sequencer idle, accepts request
req_op  in  7  vector_pkg op; only LOAD/STORE are acted on
req_addr  in  ADDR_W  tile base address
req_row_col  in  1  0 = row-major walk, 1 = column-major walk
req_num_rows  in  6  tile rows
req_num_cols  in  6  tile cols
req_id  in  1  request tag, echoed on resp_id
wr_valid  in  1  store element valid
wr_data  in  DATA_W  store element
wr_ready  out  1  store element accepted this cycle
rd_valid  out  1  load element valid; no backpressure
rd_data  out  DATA_W  load element
rd_last  out  1  final load element
sram_en  out  1  SRAM access
sram_we  out  1  SRAM write
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read
dhit  out  1  one-cycle completion pulse
resp_id  out  1  id of the completing request
resp_err  out  1  bounds error; present only with SP_BOUNDS_CHECK_EN, otherwise tied 0

Behaviour:
- Reset: one clock, CLK. Reset RST is synchronous, active-high. On RST, state = IDLE, all counters are 0, and every output is 0 except req_ready = 1.
- States: IDLE, STORE, LOAD, DRAIN, DONE.
- IDLE:
  - req_ready = 1. On req_valid, latch all request fields.
  - LOAD goes to LOAD; STORE goes to STORE.
  - Zero dimension (rows = 0 or cols = 0) goes to DONE with no SRAM access.
  - Any other op is accepted and dropped, with no response.
- Walk counters: outer/inner counters of 6 bits each. Row-major: outer = row, inner = col. Column-major: outer = col, inner = row.
- Address: base + row*ROW_STRIDE + col, computed at ADDR_W+8 bits and truncated to ADDR_W (wrap-around modulo 2^ADDR_W).
- STORE:
  - wr_ready = 1. Each cycle with wr_valid, drive sram_en = sram_we = 1, sram_wdata = wr_data, and advance the counters.
  - No wr_valid means no access and the counters hold.
  - After the final element, go to DONE.
- LOAD:
  - Issue one read per cycle (sram_en = 1, sram_we = 0).
  - The cycle after each read: rd_valid = 1, rd_data = sram_rdata.
  - After the last issue, go to DRAIN.
- DRAIN: one cycle; the last element returns with rd_last = 1. Then go to DONE.
- DONE: dhit = 1 and resp_id = latched id for exactly one cycle, then go to IDLE.
- Timing:
  - Load latency from acceptance: first rd_valid at cycle +2.
  - A load of N elements has dhit at acceptance + N + 2.
  - A store has dhit the cycle after the final wr handshake.
- Back-to-back: req_ready is low outside IDLE. The earliest next acceptance is the cycle after DONE.
- RST mid-operation: abort immediately. In-flight reads are discarded, and rd_valid/dhit are 0 the following cycle.
- Maximum tile: 63×63 elements; the element counter is 12 bits.

Optional Feature:
SP_BOUNDS_CHECK_EN
- Defined:
  - Any walk address whose untruncated value is ≥ SP_DEPTH suppresses that access: sram_en = 0, and for loads rd_data = 0 while rd_valid still pulses.
  - Sets a sticky error flag for the request. resp_err = 1 alongside dhit.
- Undefined: no check, address wraps as stated, resp_err tied 0.

Decomposition:
- vector_pkg (shared) gains:
  - sp_state_t (the state enum)
  - SP_ROW_MAJOR / SP_COL_MAJOR constants
  - sp_req_t struct (op, addr, row_col, rows, cols, id)
- LOAD/STORE encodings come from vector_pkg.
- One natural sub-module: sp_tile_addr_gen. It holds the outer/inner counters and the address computation, with outputs addr, last and advance.

Test Plan:
- LOAD, base 0x0100, row-major, 2×3, sram filled with addr low byte → reads at 0x100, 101, 102, 120, 121, 122; rd_data in that order; rd_last on the 6th; dhit at acceptance+8.
- LOAD, same tile, column-major → addresses 0x100, 120, 101, 121, 102, 122.
- STORE 1×4 with wr_valid deasserted every other cycle → exactly 4 writes in order; counters hold in gaps; dhit the cycle after the 4th handshake; resp_id matches req_id.
- LOAD with num_rows = 0, id = 1 → no sram_en; dhit with resp_id = 1 one cycle after acceptance.
- LOAD base 0xFFFE, 1×4 → addresses FFFE, FFFF, 0000, 0001. With SP_BOUNDS_CHECK_EN and SP_DEPTH = 4096, base 0x0FFE: last two accesses suppressed and resp_err = 1.
- RST asserted mid-LOAD after 2 issues → next cycle: IDLE, req_ready = 1, no rd_valid, no dhit; a new request then completes normally.
